// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, pixel format selector,
// RGB triple and the colour-bar palette used by the optional test pattern.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {CM_GRAY = 1'b0, CM_RGB = 1'b1} color_mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb_t [7:0] COLOR_BARS = '{
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };
endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with raw (undelayed) syncs and visible flag.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          visible,
  output logic          line_end,
  output logic          frame_first
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (line_end) begin
      hc <= '0;
      vc <= (vc == CW'(V_TOTAL - 1)) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  assign line_end    = (hc == CW'(H_TOTAL - 1));
  assign frame_first = (hc == '0) && (vc == '0);
  assign hsync_n = !((int'(hc) >= H_ACTIVE + H_FP) && (int'(hc) < H_ACTIVE + H_FP + H_SYNC));
  assign vsync_n = !((int'(vc) >= V_ACTIVE + V_FP) && (int'(vc) < V_ACTIVE + V_FP + V_SYNC));
  assign visible = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
endmodule

// File: rtl/vga_frame_scanner.sv
// VGA scan-out: centred, pixel-replicated framebuffer reads aligned with delayed
// sync/blank. Define VGA_TEST_PATTERN_EN to add the colour-bar test_pat input.
module vga_frame_scanner
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int SCALE      = 2,
  parameter int COLOR_MODE = 0,
  parameter int RAM_LAT    = 1,
  parameter int ADDR_W     = 19,
  parameter logic [7:0] BG_LEVEL = 8'h00,
  localparam int PIX_W     = (COLOR_MODE == 1) ? 24 : 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_pat,
`endif
  input  logic              buf_sel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              sync_blank,
  output logic              sync_b,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = $clog2((H_TOTAL > V_TOTAL ? H_TOTAL : V_TOTAL) + 1);
  localparam int X0      = (H_ACTIVE - IMG_W * SCALE) / 2;
  localparam int X1      = X0 + IMG_W * SCALE;
  localparam int Y0      = (V_ACTIVE - IMG_H * SCALE) / 2;
  localparam int Y1      = Y0 + IMG_H * SCALE;
  localparam int STAGES  = RAM_LAT + 1;
  localparam int RW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [RW-1:0]     RMAX   = RW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] IMG_SZ = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] ROW_W  = ADDR_W'(IMG_W);
  localparam color_mode_e CMODE = (COLOR_MODE == 1) ? CM_RGB : CM_GRAY;

  if (SCALE < 1)                    begin : g_bad_scale $fatal(1, "SCALE must be >= 1"); end
  if (IMG_W * SCALE > H_ACTIVE)     begin : g_bad_w     $fatal(1, "IMG_W*SCALE exceeds H_ACTIVE"); end
  if (IMG_H * SCALE > V_ACTIVE)     begin : g_bad_h     $fatal(1, "IMG_H*SCALE exceeds V_ACTIVE"); end
  if (longint'(2) * IMG_W * IMG_H > (longint'(1) << ADDR_W))
                                    begin : g_bad_a     $fatal(1, "two image buffers exceed ADDR_W"); end
  if (RAM_LAT < 1 || RAM_LAT > 4)   begin : g_bad_lat   $fatal(1, "RAM_LAT must be 1..4"); end

  typedef struct packed {
    logic       hs_n;
    logic       vs_n;
    logic       vis;
    logic       win;
    logic       fs;
`ifdef VGA_TEST_PATTERN_EN
    logic       pat;
    logic [2:0] bar;
`endif
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, default: '0};

  logic [CW-1:0]     hc, vc;
  logic              hsync_n, vsync_n, visible, line_end, frame_first;
  logic              in_rows, in_win, at_x0;
  logic              buf_q, buf_now;
  logic [ADDR_W-1:0] row_start, row_cur;
  logic [RW-1:0]     x_rep, y_rep;
  ctl_t              ctl_s0, out_c;
  ctl_t              ctl_pipe [STAGES:1];
  rgb_t              mem_pix, pix;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CW(CW)
  ) u_tgen (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .visible(visible), .line_end(line_end), .frame_first(frame_first)
  );

  assign in_rows = (int'(vc) >= Y0) && (int'(vc) < Y1);
  assign in_win  = in_rows && (int'(hc) >= X0) && (int'(hc) < X1);
  assign at_x0   = (int'(hc) == X0);
  // The frame-start cycle must already see the newly selected buffer when X0=Y0=0.
  assign buf_now = frame_first ? buf_sel : buf_q;
  assign row_cur = frame_first ? (buf_now ? IMG_SZ : '0) : row_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q     <= 1'b0;
      row_start <= '0;
      y_rep     <= '0;
      x_rep     <= '0;
      mem_addr  <= '0;
    end else begin
      buf_q <= buf_now;
      if (frame_first) begin
        row_start <= row_cur;
        y_rep     <= '0;
      end else if (line_end && in_rows) begin
        if (y_rep == RMAX) begin
          row_start <= row_start + ROW_W;
          y_rep     <= '0;
        end else begin
          y_rep <= y_rep + 1'b1;
        end
      end
      if (in_win) begin
        if (at_x0) begin
          mem_addr <= row_cur;
          x_rep    <= '0;
        end else if (x_rep == RMAX) begin
          mem_addr <= mem_addr + 1'b1;
          x_rep    <= '0;
        end else begin
          x_rep <= x_rep + 1'b1;
        end
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic          pat_q, pat_now;
  logic [CW-1:0] bar_px;
  logic [2:0]    bar_idx;

  assign pat_now = frame_first ? test_pat : pat_q;

  // Bar index tracks hc/BAR_W incrementally so no divider is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= 1'b0;
      bar_px  <= '0;
      bar_idx <= '0;
    end else begin
      pat_q <= pat_now;
      if (line_end) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == CW'(BAR_W - 1)) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_px <= bar_px + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    ctl_s0      = CTL_IDLE;
    ctl_s0.hs_n = hsync_n;
    ctl_s0.vs_n = vsync_n;
    ctl_s0.vis  = visible;
    ctl_s0.win  = in_win;
    ctl_s0.fs   = frame_first;
`ifdef VGA_TEST_PATTERN_EN
    ctl_s0.pat  = pat_now;
    ctl_s0.bar  = bar_idx;
`endif
  end

  // Control rides alongside the address so it meets mem_rdata in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= STAGES; i++) ctl_pipe[i] <= CTL_IDLE;
    end else begin
      ctl_pipe[1] <= ctl_s0;
      for (int i = 2; i <= STAGES; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  assign out_c = ctl_pipe[STAGES];

  if (CMODE == CM_RGB) begin : g_rgb
    assign mem_pix = mem_rdata;
  end else begin : g_gray
    assign mem_pix = {mem_rdata, mem_rdata, mem_rdata};
  end

  always_comb begin
    pix = '0;
    if (out_c.vis) begin
      if (!out_c.win) begin
        pix = {BG_LEVEL, BG_LEVEL, BG_LEVEL};
      end else begin
`ifdef VGA_TEST_PATTERN_EN
        pix = out_c.pat ? COLOR_BARS[out_c.bar] : mem_pix;
`else
        pix = mem_pix;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      sync_blank  <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= out_c.hs_n;
      vga_vsync   <= out_c.vs_n;
      sync_blank  <= out_c.vis;
      red         <= pix.r;
      green       <= pix.g;
      blue        <= pix.b;
      frame_start <= out_c.fs;
    end
  end

  assign sync_b = 1'b0;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench on a shrunken 64x48 raster: gray/SCALE=2/RAM_LAT=1 and RGB/SCALE=1/RAM_LAT=3.
module tb_vga_frame_scanner;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 4;
  localparam int AW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, buf_sel;
  logic [AW-1:0] ma_a, ma_b;
  logic [7:0]    rd_a;
  logic [23:0]   rd_b;
  logic [AW-1:0] pb1, pb2;
  logic hs_a, vs_a, bl_a, sb_a, fs_a, hs_b, vs_b, bl_b, sb_b, fs_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  int cyc, total, bad, fs_cnt_a;

  vga_frame_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(32), .IMG_H(24), .SCALE(2), .COLOR_MODE(0), .RAM_LAT(1),
    .ADDR_W(AW), .BG_LEVEL(8'h00)
  ) dut_a (
    .clk(clk), .rst(rst), .buf_sel(buf_sel), .mem_addr(ma_a), .mem_rdata(rd_a),
    .vga_hsync(hs_a), .vga_vsync(vs_a), .sync_blank(bl_a), .sync_b(sb_a),
    .red(r_a), .green(g_a), .blue(b_a), .frame_start(fs_a)
  );

  vga_frame_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(32), .IMG_H(24), .SCALE(1), .COLOR_MODE(1), .RAM_LAT(3),
    .ADDR_W(AW), .BG_LEVEL(8'h20)
  ) dut_b (
    .clk(clk), .rst(rst), .buf_sel(buf_sel), .mem_addr(ma_b), .mem_rdata(rd_b),
    .vga_hsync(hs_b), .vga_vsync(vs_b), .sync_blank(bl_b), .sync_b(sb_b),
    .red(r_b), .green(g_b), .blue(b_b), .frame_start(fs_b)
  );

  // RAM models: A returns addr[7:0] after 1 cycle, B returns {12,34,addr[7:0]} after 3.
  always @(posedge clk) begin
    rd_a <= ma_a[7:0];
    pb1  <= ma_b;
    pb2  <= pb1;
    rd_b <= {8'h12, 8'h34, pb2[7:0]};
  end

  // cyc equals the index of the counter state held during the current cycle.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst && fs_a === 1'b1) fs_cnt_a <= fs_cnt_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int n);
    int guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      total++;
      bad++;
      $error("FAIL wait_cycle observed=%0d expected=%0d", cyc, n);
    end
  endtask

  initial begin
    total = 0; bad = 0; fs_cnt_a = 0;
    rst = 1'b1; buf_sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hsync", hs_a, 1);
    chk("rst_vsync", vs_a, 1);
    chk("rst_blank", bl_a, 0);
    chk("rst_sync_b", sb_a, 0);
    chk("rst_rgb", {r_a, g_a, b_a}, 0);
    chk("rst_fs", fs_a, 0);
    chk("rst_addr", ma_a, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    at(2);    chk("fs_early", fs_a, 0); chk("blank_early", bl_a, 0);
    at(3);    chk("fs_L", fs_a, 1); chk("blank_first", bl_a, 1); chk("px0", r_a, 0); chk("addr_h2", ma_a, 1);
    at(4);    chk("fs_once", fs_a, 0); chk("px1", r_a, 0);
    at(5);    chk("px2_r", r_a, 1); chk("px2_g", g_a, 1); chk("fs_b_L5", fs_b, 1);
    at(6);    chk("px3_b", b_a, 1);
    at(8);    chk("px5", r_a, 2);
    at(66);   chk("px63", r_a, 31);
    at(67);   chk("hblank", bl_a, 0); chk("hblank_rgb", r_a, 0);
    at(70);   chk("hs_pre", hs_a, 1);
    at(71);   chk("hs_start", hs_a, 0);
    at(78);   chk("hs_end", hs_a, 0);
    at(79);   chk("hs_post", hs_a, 1);
    at(87);   chk("line1_px4", r_a, 2);
    at(161);  chk("line2_addr", ma_a, 32);
    at(163);  chk("line2_px0", r_a, 32);

    at(977);  chk("b_win_addr0", ma_b, 0);
    at(981);  chk("b_red", r_b, 8'h12); chk("b_green", g_b, 8'h34); chk("b_blue0", b_b, 0); chk("b_blank", bl_b, 1);
    at(982);  chk("b_blue1", b_b, 1);
    at(1012); chk("b_last_col", b_b, 31);
    at(1013); chk("b_bg_right_b", b_b, 8'h20); chk("b_bg_right_r", r_b, 8'h20);
    at(1025); chk("b_bg_vis", bl_b, 1); chk("b_bg_r", r_b, 8'h20);
    at(1035); chk("b_hblank", bl_b, 0); chk("b_hblank_r", r_b, 0);

    at(1600); buf_sel = 1'b1;
    at(1620); chk("b_bg_left_blank", bl_b, 1); chk("b_bg_left_b", b_b, 8'h20);
    at(1626); chk("b_row8_blue", b_b, 5); chk("b_row8_red", r_b, 8'h12);
    at(2401); chk("a_midframe_base0", ma_a, 480);
    at(4002); chk("vs_a_pre", vs_a, 1);
    at(4003); chk("vs_a_low", vs_a, 0);
    at(4004); chk("vs_b_pre", vs_b, 1);
    at(4005); chk("vs_b_low", vs_b, 0);
    at(4481); chk("a_frame1_base", ma_a, 768);
    at(4482); chk("fs_f1_pre", fs_a, 0);
    at(4483); chk("fs_f1", fs_a, 1);
    at(4641); chk("a_frame1_line2", ma_a, 800);
    at(5457); chk("b_frame1_base", ma_b, 768);
    at(8963); chk("fs_f2", fs_a, 1);
    at(8970); chk("fs_count", fs_cnt_a, 3);

    at(11400); chk("pre_rst_blank", bl_a, 1); chk("pre_rst_px", r_a, 242);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_blank", bl_a, 0);
    chk("midrst_rgb", {r_a, g_a, b_a}, 0);
    chk("midrst_hs", hs_a, 1);
    chk("midrst_addr", ma_a, 0);
    chk("midrst_b_rgb", {r_b, g_b, b_b}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    at(1);    chk("post_rst_addr", ma_a, 768);
    at(2);    chk("post_rst_fs_pre", fs_a, 0);
    at(3);    chk("post_rst_fs", fs_a, 1);
    at(5);    chk("post_rst_fs_b", fs_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
